// File: rtl/craft_tweakey_stream_pkg.sv
// Shared constants and helpers for the CRAFT tweakey stream: the Q nibble permutation,
// the tweakey index helper and the FSM state encoding.
package craft_tweakey_stream_pkg;

  // Q as packed nibbles, entry 0 in the most-significant nibble
  localparam logic [63:0] CRAFT_Q = 64'hCAF5E892B374601D;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t STREAM = 2'd1;
  localparam state_t DONE   = 2'd2;

  function automatic int chunk_w(input int w);
    int nb;
    nb = 64 / w;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // Output nibble i takes input nibble Q[i]; nibble 0 is bits [63:60]
  function automatic logic [63:0] q_perm(input logic [63:0] t);
    logic [63:0] r;
    int          src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = int'(CRAFT_Q[63-4*i -: 4]);
      r[63-4*i -: 4] = t[63-4*src -: 4];
    end
    return r;
  endfunction

  function automatic logic [1:0] tk_idx(input logic [7:0] round);
    return 2'(round % 8'd4);
  endfunction

endpackage

// File: rtl/craft_tweakey_stream_if.sv
// Ready/valid tweakey beat stream from the generator to the round datapath.
interface craft_tweakey_stream_if
  import craft_tweakey_stream_pkg::*;
#(
  parameter int W = 4
);
  localparam int CW = chunk_w(W);

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [7:0]    out_round;
  logic [CW-1:0] out_chunk;
  logic          out_last_chunk;
  logic          out_last_round;

  modport master (
    output out_valid, out_data, out_round, out_chunk, out_last_chunk, out_last_round,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_round, out_chunk, out_last_chunk, out_last_round,
    output out_ready
  );

endinterface

// File: rtl/craft_tweakey_stream_perm.sv
// Combinational Q nibble permutation of the 64-bit tweak, used on the load path.
module craft_tweakey_stream_perm
  import craft_tweakey_stream_pkg::*;
(
  input  logic [63:0] tweak,
  output logic [63:0] tweak_q
);

  assign tweak_q = q_perm(tweak);

endmodule

// File: rtl/craft_tweakey_stream.sv
// CRAFT tweakey generator: latches key/tweak on start and streams TK[round mod 4]
// W bits per beat over a ready/valid interface, in forward or reverse round order.
module craft_tweakey_stream
  import craft_tweakey_stream_pkg::*;
#(
  parameter int W      = 4,
  parameter int ROUNDS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [127:0]           key,
  input  logic signed [63:0]            tweak,
  input  logic                          dec,
  output logic                          busy,
  output logic                          done,
  craft_tweakey_stream_if.master        os
);

  localparam int NB = 64 / W;
  localparam int CW = chunk_w(W);
  localparam int LW = $clog2(W);

  logic [63:0]    tweak_q;
  state_t         state_p0;
  logic [7:0]     round_p0;
  logic [CW-1:0]  chunk_p0;
  logic           dec_p0;
  logic [63:0]    tk_p0 [4];

  logic           stream;
  logic           fire;
  logic           last_chunk;
  logic           last_round;
  logic [63:0]    tk_cur;
  logic [63:0]    tk_shift;
  logic [CW+LW-1:0] sh;

  craft_tweakey_stream_perm u_perm (
    .tweak   (tweak),
    .tweak_q (tweak_q)
  );

  assign stream     = (state_p0 == STREAM);
  assign fire       = stream & os.out_ready;
  assign last_chunk = (chunk_p0 == CW'(NB - 1));
  assign last_round = dec_p0 ? (round_p0 == 8'd0) : (round_p0 == 8'(ROUNDS - 1));

  // Beat select: shift the registered tweakey so the current beat sits in the top W bits
  assign tk_cur   = tk_p0[tk_idx(round_p0)];
  assign sh       = {chunk_p0, {LW{1'b0}}};
  assign tk_shift = tk_cur << sh;

  assign os.out_valid      = stream;
  assign os.out_data       = stream ? W'(tk_shift >> (64 - W)) : '0;
  assign os.out_round      = stream ? round_p0 : 8'd0;
  assign os.out_chunk      = stream ? chunk_p0 : '0;
  assign os.out_last_chunk = stream & last_chunk;
  assign os.out_last_round = stream & last_round;
  assign busy              = stream;
  assign done              = (state_p0 == DONE);

  // Stage p0: control state (reset) and latched tweakeys (no reset, loaded on start)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      round_p0 <= 8'd0;
      chunk_p0 <= '0;
      dec_p0   <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            state_p0 <= STREAM;
            dec_p0   <= dec;
            round_p0 <= dec ? 8'(ROUNDS - 1) : 8'd0;
            chunk_p0 <= '0;
          end
        end
        STREAM: begin
          if (fire) begin
            if (last_chunk) begin
              chunk_p0 <= '0;
              if (last_round) state_p0 <= DONE;
              else round_p0 <= dec_p0 ? round_p0 - 8'd1 : round_p0 + 8'd1;
            end else begin
              chunk_p0 <= chunk_p0 + CW'(1);
            end
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_p0 == IDLE && start) begin
      tk_p0[0] <= key[127:64] ^ tweak;
      tk_p0[1] <= key[63:0]   ^ tweak;
      tk_p0[2] <= key[127:64] ^ tweak_q;
      tk_p0[3] <= key[63:0]   ^ tweak_q;
    end
  end

endmodule
